// File: rtl/cb_updown_count_reg.sv
// Registered up/down counter stage: sync load, enable, terminal count, cascade carry.
// Optional build macro CB_COUNT_SATURATE_EN: hold at the limit instead of wrapping.
module cb_updown_count_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INIT  = 0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TCP
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] r_q;
    logic             r_tcp;

    logic             w_term;
    logic             w_co;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;

    assign w_term = (UP & (r_q == '1)) | (~UP & (r_q == '0));
    assign w_co   = CE & ~LD & w_term;

    assign w_inc = r_q + WIDTH'(1);
    assign w_dec = r_q - WIDTH'(1);

`ifdef CB_COUNT_SATURATE_EN
    assign w_step = w_term ? r_q : (UP ? w_inc : w_dec);
`else
    assign w_step = UP ? w_inc : w_dec;
`endif

    // Ternaries rather than if/else so an X on LD, CE or UP propagates into Q.
    assign w_next = LD ? D : (CE ? w_step : r_q);

    always_ff @(posedge CK) begin
        if (CD) begin
            r_q   <= INIT_V;
            r_tcp <= 1'b0;
        end else begin
            r_q   <= w_next;
            r_tcp <= w_co;
        end
    end

    assign Q   = r_q;
    assign CO  = w_co;
    assign TCP = r_tcp;

endmodule

// File: tb/tb_cb_updown_count_reg.sv
// Self-checking bench for cb_updown_count_reg: directed scenarios plus random
// stimulus against an arithmetic reference model; also a two-stage cascade.
module tb_cb_updown_count_reg;

    localparam int W     = 8;
    localparam int INITV = 0;
    localparam int MODV  = 256;
`ifdef CB_COUNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CK = 1'b0;
    logic         cd = 1'b1;
    logic         ce = 1'b0;
    logic         up = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] d  = '0;
    logic [W-1:0] q;
    logic         co;
    logic         tcp;

    logic         c_cd = 1'b1;
    logic         c_ce = 1'b0;
    logic         c_up = 1'b1;
    logic         c_ld = 1'b0;
    logic [7:0]   c_d  = '0;
    logic [3:0]   lo_q;
    logic [3:0]   hi_q;
    logic         lo_co, hi_co, lo_tcp, hi_tcp;

    int total = 0;
    int bad   = 0;

    int m_q   = INITV;
    bit m_tcp = 1'b0;
    bit m_co  = 1'b0;
    bit s_cd, s_ld, s_ce, s_up;
    int s_d;

    always #5 CK = ~CK;

    cb_updown_count_reg #(.WIDTH(W), .INIT(INITV)) dut (
        .CK(CK), .CD(cd), .CE(ce), .UP(up), .LD(ld), .D(d),
        .Q(q), .CO(co), .TCP(tcp)
    );

    cb_updown_count_reg #(.WIDTH(4), .INIT(0)) u_lo (
        .CK(CK), .CD(c_cd), .CE(c_ce), .UP(c_up), .LD(c_ld), .D(c_d[3:0]),
        .Q(lo_q), .CO(lo_co), .TCP(lo_tcp)
    );

    cb_updown_count_reg #(.WIDTH(4), .INIT(0)) u_hi (
        .CK(CK), .CD(c_cd), .CE(lo_co), .UP(c_up), .LD(c_ld), .D(c_d[7:4]),
        .Q(hi_q), .CO(hi_co), .TCP(hi_tcp)
    );

    // Apply inputs shortly after an edge and predict CO from the model state.
    task automatic drive(input bit icd, input bit ild, input bit ice, input bit iup, input int id);
        cd = icd; ld = ild; ce = ice; up = iup; d = id[W-1:0];
        s_cd = icd; s_ld = ild; s_ce = ice; s_up = iup; s_d = id % MODV;
        m_co = ice && !ild && (iup ? (m_q == MODV - 1) : (m_q == 0));
        #1;
    endtask

    // Advance the model by one edge, then wait for the DUT edge.
    task automatic advance();
        bit term;
        term = s_up ? (m_q == MODV - 1) : (m_q == 0);
        if (s_cd) begin
            m_q   = INITV;
            m_tcp = 1'b0;
        end else begin
            m_tcp = m_co;
            if (s_ld)
                m_q = s_d;
            else if (s_ce && !(SAT && term))
                m_q = s_up ? (m_q + 1) % MODV : (m_q + MODV - 1) % MODV;
        end
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0);
            advance();
        end
        total++;
        if (q !== INITV[W-1:0]) begin
            bad++; $display("FAIL reset_q: got %0h want %0h", q, INITV);
        end
        total++;
        if (tcp !== 1'b0) begin
            bad++; $display("FAIL reset_tcp: got %0b want 0", tcp);
        end
        drive(0, 0, 1, 0, 0);
        total++;
        if (co !== 1'b1) begin
            bad++; $display("FAIL reset_co_down: got %0b want 1", co);
        end
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, 1, 0);
            advance();
            total++;
            if (q !== 8'(i) || q !== m_q[W-1:0]) begin
                bad++; $display("FAIL count_up_q[%0d]: got %0h want %0h", i, q, i);
            end
            total++;
            if (tcp !== 1'b0) begin
                bad++; $display("FAIL count_up_tcp[%0d]: got %0b want 0", i, tcp);
            end
        end
    endtask

    // Shared body for the directed sequences: CO before the edge, Q/TCP after.
    task automatic seq_step(input string nm, input bit ild, input bit ice, input bit iup, input int id);
        drive(0, ild, ice, iup, id);
        total++;
        if (co !== m_co) begin
            bad++; $display("FAIL %s_co: got %0b want %0b (q=%0h)", nm, co, m_co, q);
        end
        advance();
        total++;
        if (q !== m_q[W-1:0]) begin
            bad++; $display("FAIL %s_q: got %0h want %0h", nm, q, m_q);
        end
        total++;
        if (tcp !== m_tcp) begin
            bad++; $display("FAIL %s_tcp: got %0b want %0b", nm, tcp, m_tcp);
        end
    endtask

    task automatic test_wrap_up();
        int tcp_cnt = 0;
        seq_step("wrap_up_ld", 1, 0, 1, 'hFE);
        for (int i = 0; i < 3; i++) begin
            seq_step("wrap_up", 0, 1, 1, 0);
            if (tcp) tcp_cnt++;
        end
        total++;
        if (tcp_cnt != (SAT ? 2 : 1)) begin
            bad++; $display("FAIL wrap_up_tcp_count: got %0d want %0d", tcp_cnt, SAT ? 2 : 1);
        end
    endtask

    task automatic test_wrap_down();
        seq_step("wrap_dn_ld", 1, 0, 0, 'h02);
        for (int i = 0; i < 3; i++) seq_step("wrap_dn", 0, 1, 0, 0);
        seq_step("dir_switch", 0, 1, 1, 0);
        seq_step("dir_after", 0, 0, 1, 0);
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 1, 'h55);
        advance();
        total++;
        if (q !== INITV[W-1:0]) begin
            bad++; $display("FAIL prio_cd_q: got %0h want %0h", q, INITV);
        end
        seq_step("prio_ld", 1, 1, 1, 'h55);
        total++;
        if (q !== 8'h55) begin
            bad++; $display("FAIL prio_ld_val: got %0h want 55", q);
        end
        for (int i = 0; i < 3; i++) seq_step("prio_hold", 0, 0, 1, 'hAA);
    endtask

    task automatic test_reset_mid();
        seq_step("mid_ld", 1, 0, 1, 'hFF);
        drive(1, 0, 1, 1, 0);
        total++;
        if (co !== 1'b1) begin
            bad++; $display("FAIL mid_co: got %0b want 1", co);
        end
        advance();
        total++;
        if (q !== INITV[W-1:0] || tcp !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got q=%0h tcp=%0b want q=%0h tcp=0", q, tcp, INITV);
        end
        drive(0, 0, 0, 1, 0);
        advance();
        total++;
        if (tcp !== 1'b0) begin
            bad++; $display("FAIL mid_tcp_after: got %0b want 0", tcp);
        end
    endtask

    task automatic test_random();
        int dsel;
        int dv;
        for (int i = 0; i < 400; i++) begin
            dsel = int'($urandom_range(0, 4));
            case (dsel)
                0: dv = 0;
                1: dv = 1;
                2: dv = MODV - 2;
                3: dv = MODV - 1;
                default: dv = int'($urandom_range(0, MODV - 1));
            endcase
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) < 5, dv);
            total++;
            if (co !== m_co) begin
                bad++; $display("FAIL rand_co[%0d]: got %0b want %0b", i, co, m_co);
            end
            advance();
            total++;
            if (q !== m_q[W-1:0] || tcp !== m_tcp) begin
                bad++; $display("FAIL rand_state[%0d]: got q=%0h tcp=%0b want q=%0h tcp=%0b",
                                i, q, tcp, m_q, m_tcp);
            end
        end
    endtask

    task automatic test_cascade();
        int cm;
        c_cd = 1'b1; c_ld = 1'b0; c_ce = 1'b0; c_up = 1'b1;
        @(posedge CK); #1;
        c_cd = 1'b0; c_ld = 1'b1; c_d = 8'h0E;
        @(posedge CK); #1;
        cm = 'h0E;
        total++;
        if ({hi_q, lo_q} !== 8'(cm)) begin
            bad++; $display("FAIL casc_load: got %0h want %0h", {hi_q, lo_q}, cm);
        end
        c_ld = 1'b0; c_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CK); #1;
            cm = (cm + 1) % 256;
            total++;
            if ({hi_q, lo_q} !== 8'(cm)) begin
                bad++; $display("FAIL casc_q[%0d]: got %0h want %0h", i, {hi_q, lo_q}, cm);
            end
            total++;
            if (hi_tcp !== 1'b0) begin
                bad++; $display("FAIL casc_hi_tcp[%0d]: got %0b want 0", i, hi_tcp);
            end
        end
        c_ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_priority();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
